pulse_meas: RTL and testbench

Capture-side companion to the glitch pulse generator in the glitcher. After an `arm` strobe, it measures two things on an asynchronous input: the delay until the input's next rising edge, and that pulse's high width, both in `clk` cycles. Results are held with a valid/ack handshake until the controller reads them. Typical use is timing target responses (trigger-to-reaction, reset/IRQ pulse widths) and verifying generator output in loopback.

---
 rtl/pulse_meas.sv | 111 +++++++++++
 tb/tb_pulse_meas.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meas.sv
// Measures arm-to-rising-edge delay and high width of an asynchronous input,
// holding the result under a valid/ack handshake until the controller reads it.
module pulse_meas #(
    parameter int                CNT_W   = 16,
    parameter logic [CNT_W-1:0]  TIMEOUT = 16'd50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             ack,
    input  logic             din,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] delay,
    output logic [CNT_W-1:0] width
);

    typedef enum logic [2:0] {IDLE, WAIT_LOW, WAIT_RISE, HIGH, DONE} state_t;

    state_t           state, state_nxt;
    logic             sync1, ds;
    logic [CNT_W-1:0] delay_nxt, width_nxt;
    logic             timeout_nxt;

    // din is asynchronous: only the second synchronizer stage feeds decisions
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            ds      <= 1'b0;
            state   <= IDLE;
            delay   <= '0;
            width   <= '0;
            timeout <= 1'b0;
        end else begin
            sync1   <= din;
            ds      <= sync1;
            state   <= state_nxt;
            delay   <= delay_nxt;
            width   <= width_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        delay_nxt   = delay;
        width_nxt   = width;
        timeout_nxt = timeout;
        case (state)
            IDLE: begin
                if (arm) begin
                    delay_nxt   = '0;
                    width_nxt   = '0;
                    timeout_nxt = 1'b0;
                    state_nxt   = ds ? WAIT_LOW : WAIT_RISE;
                end
            end
            WAIT_LOW: begin
                // a pulse already high at arm time is skipped, but still counts as delay
                if (delay == TIMEOUT) begin
                    state_nxt   = DONE;
                    timeout_nxt = 1'b1;
                    width_nxt   = '0;
                end else begin
                    delay_nxt = delay + CNT_W'(1);
                    if (!ds) state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (ds) begin
                    width_nxt = CNT_W'(1);
                    state_nxt = HIGH;
                end else if (delay == TIMEOUT) begin
                    state_nxt   = DONE;
                    timeout_nxt = 1'b1;
                    width_nxt   = '0;
                end else begin
                    delay_nxt = delay + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!ds) begin
                    state_nxt = DONE;
                end else if (width == TIMEOUT) begin
                    state_nxt   = DONE;
                    timeout_nxt = 1'b1;
                end else begin
                    width_nxt = width + CNT_W'(1);
                end
            end
            DONE: begin
                if (ack) begin
                    if (arm) begin
                        delay_nxt   = '0;
                        width_nxt   = '0;
                        timeout_nxt = 1'b0;
                        state_nxt   = ds ? WAIT_LOW : WAIT_RISE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == WAIT_LOW) || (state == WAIT_RISE) || (state == HIGH);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_pulse_meas.sv
// Bench for pulse_meas: directed scenarios plus random din/arm/ack/rst traffic,
// checked every cycle against a history-scan model of the measurement rules.
module tb_pulse_meas;

    localparam int T = 100;

    logic        clk, rst, arm, ack, din;
    logic        busy, valid, timeout;
    logic [15:0] delay, width;

    pulse_meas #(.CNT_W(16), .TIMEOUT(16'd100)) dut (
        .clk(clk), .rst(rst), .arm(arm), .ack(ack), .din(din),
        .busy(busy), .valid(valid), .timeout(timeout),
        .delay(delay), .width(width)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ds value seen by the controller at each edge, indexed by edge number
    bit s_hist [0:65535];
    int n_edge = -1;
    bit mff1 = 1'b0, mff2 = 1'b0;
    bit m_act = 1'b0;
    int m_a = 0;
    bit e_busy, e_valid, e_to, h_to;
    int e_dl, e_wd, h_dl, h_wd;
    bit chk_en = 1'b0;

    // Outcome of a measurement armed at edge a, as seen right after edge n.
    function automatic void eval(input int a, input int n, output bit bz, output bit vd,
                                 output bit to, output int dl, output int wd);
        bit low;
        int r;
        low = !s_hist[a];
        r   = -1;
        bz = 1'b1; vd = 1'b0; to = 1'b0; dl = n - a; wd = 0;
        for (int e = a + 1; e <= n; e++) begin
            if (r < 0) begin
                if (low && s_hist[e]) begin
                    r = e; dl = e - a - 1; wd = 1;
                end else if (e - a - 1 == T) begin
                    bz = 1'b0; vd = 1'b1; to = 1'b1; dl = T; wd = 0;
                    return;
                end else begin
                    if (!s_hist[e]) low = 1'b1;
                    dl = e - a;
                end
            end else begin
                if (!s_hist[e]) begin
                    bz = 1'b0; vd = 1'b1;
                    return;
                end else if (e - r == T) begin
                    bz = 1'b0; vd = 1'b1; to = 1'b1; wd = T;
                    return;
                end else begin
                    wd = e - r + 1;
                end
            end
        end
    endfunction

    initial begin : model
        bit bz, vd, to;
        int dl, wd;
        forever begin
            @(posedge clk);
            n_edge++;
            s_hist[n_edge] = mff2;
            if (rst) begin mff2 = 1'b0; mff1 = 1'b0; end
            else begin mff2 = mff1; mff1 = din; end
            if (rst) begin
                m_act = 1'b0; h_dl = 0; h_wd = 0; h_to = 1'b0;
            end else if (!m_act) begin
                if (arm) begin m_act = 1'b1; m_a = n_edge; end
            end else begin
                eval(m_a, n_edge - 1, bz, vd, to, dl, wd);
                if (vd && ack) begin
                    if (arm) m_a = n_edge;
                    else begin m_act = 1'b0; h_dl = dl; h_wd = wd; h_to = to; end
                end
            end
            if (m_act) eval(m_a, n_edge, e_busy, e_valid, e_to, e_dl, e_wd);
            else begin
                e_busy = 1'b0; e_valid = 1'b0; e_to = h_to; e_dl = h_dl; e_wd = h_wd;
            end
            chk_en = 1'b1;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy",  int'(busy),  int'(e_busy));
                chk("valid", int'(valid), int'(e_valid));
                chk("delay", int'(delay), e_dl);
                chk("width", int'(width), e_wd);
                if (e_valid) chk("timeout", int'(timeout), int'(e_to));
            end
        end
    end

    // Iteration e sets the inputs sampled at edge Ee (arm is at E0)
    task automatic run(input int k, input int n, input bit hi, input int len,
                       input int arm2, input int rst_at);
        for (int e = -3; e < len; e++) begin
            @(negedge clk);
            arm = (e == 0) || (e == arm2);
            rst = (e == rst_at);
            din = (hi && e < 5) || (e >= k && e < k + n);
        end
        @(negedge clk);
        arm = 1'b0;
        rst = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1; arm = 1'b0; din = 1'b0;
        @(negedge clk);
        ack = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic lit(input string nm, input int dl, input int wd, input int to, input int vd);
        chk({nm, "_delay"},   int'(delay),   dl);
        chk({nm, "_width"},   int'(width),   wd);
        chk({nm, "_timeout"}, int'(timeout), to);
        chk({nm, "_valid"},   int'(valid),   vd);
        chk({nm, "_model_delay"}, e_dl, dl);
        chk({nm, "_model_width"}, e_wd, wd);
    endtask

    initial begin : stim
        int runl;
        rst = 1'b1; arm = 1'b0; ack = 1'b0; din = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lit("reset", 0, 0, 0, 0);
        chk("reset_busy", int'(busy), 0);

        run(10, 5, 1'b0, 20, -100, -100);
        lit("basic", 11, 5, 0, 1);
        do_ack();
        chk("ack_valid", int'(valid), 0);
        chk("ack_hold_delay", int'(delay), 11);

        run(1000, 0, 1'b0, 106, -100, -100);
        lit("rise_to", 100, 0, 1, 1);
        do_ack();

        run(20, 3, 1'b1, 30, -100, -100);
        lit("hi_at_arm", 21, 3, 0, 1);
        do_ack();

        run(4, 1000, 1'b0, 110, -100, -100);
        lit("width_to", 5, 100, 1, 1);
        do_ack();

        run(10, 5, 1'b0, 20, 14, -100);
        lit("arm_in_high", 11, 5, 0, 1);
        @(negedge clk);
        ack = 1'b1; arm = 1'b1; din = 1'b0;
        @(negedge clk);
        ack = 1'b0; arm = 1'b0;
        chk("rearm_busy",  int'(busy),  1);
        lit("rearm", 0, 0, 0, 0);
        repeat (105) @(negedge clk);
        do_ack();

        run(5, 20, 1'b0, 11, -100, 10);
        lit("rst_mid", 0, 0, 0, 0);
        chk("rst_mid_busy", int'(busy), 0);
        din = 1'b0;
        repeat (4) @(negedge clk);
        run(0, 1, 1'b0, 6, -100, -100);
        lit("after_rst", 1, 1, 0, 1);
        do_ack();

        runl = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (runl == 0) begin
                din  = !din;
                runl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(90, 130))
                                                   : int'($urandom_range(1, 25));
            end
            runl--;
            arm = ($urandom_range(0, 15) == 0);
            ack = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 999) == 0);
        end
        arm = 1'b0; ack = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
